hybrid_cipher_stream: RTL
=========================

HYBRID_CIPHER_STREAM -- requirements
Module: hybrid_cipher_stream

Interface
REQ-001 Parameter KEY_MAX, default 16, meaning maximum key length in characters (range 2..256).
REQ-002 Parameter KW, default $clog2(KEY_MAX), meaning key index/length counter width.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- clr  in  1  synchronous clear: discards the key and returns to IDLE.
- key_valid  in  1  key character offered.
- key_data  in  8  key character, ASCII 'A'-'Z'.
- key_last  in  1  marks the final key character.
- key_ready  out  1  high in IDLE and LOAD.
- mode  in  1  0 = encrypt, 1 = decrypt; sampled per accepted input beat.
- in_valid  in  1  input beat offered.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  16  encrypt: [7:0] = plaintext letter; decrypt: [15:8] = row digit, [7:0] = column digit.
- out_valid  out  1  output beat held.
- out_ready  in  1  downstream accepts the output.
- out_data  out  16  encrypt: [15:8] = row digit, [7:0] = column digit; decrypt: [15:8] = 8'h00, [7:0] = letter.
- out_err  out  1  current output beat is an invalid-input marker.
- key_len  out  KW+1  number of stored key characters.

Function
REQ-004 The FSM SHALL have three states: IDLE -> LOAD on the first accepted key_valid; LOAD -> RUN on an accepted beat with key_last; RUN -> IDLE only on clr or rst.
REQ-005 Key beats SHALL be accepted in IDLE and LOAD only. A letter is written at key_len and key_len increments. A non-letter is dropped without advancing key_len.
REQ-006 When key_len reaches KEY_MAX, the FSM SHALL enter RUN as if key_last had been given. A key_last arriving on a dropped character SHALL still enter RUN if key_len >= 1, otherwise stay in IDLE.
REQ-007 in_ready SHALL = (state==RUN) && (!out_valid || out_ready).
- Latency: exactly one cycle, accepted beat to out_valid.
- Full throughput of one beat per cycle is required.
REQ-008 Encrypt SHALL compute:
- c = (p + k) mod 26, with p, k the 0..25 letter indices and k = key[kidx].
- out_data = {"1"+c/6, "1"+c%6}, a 6-column Polybius grid with rows '1'-'5' and columns '1'-'6'.
REQ-009 Decrypt SHALL compute:
- c = (row-'1')*6 + (col-'1').
- p = (c - k + 26) mod 26, output as 'A'+p.
REQ-010 Invalid input SHALL produce out_data=16'h3F3F ("??") and out_err=1, without advancing kidx. Invalid input is:
- encrypt: a byte outside 'A'-'Z';
- decrypt: row outside '1'-'5', column outside '1'-'6', or c>25.
REQ-011 kidx SHALL advance only on a valid accepted beat, and SHALL wrap from key_len-1 to 0.
REQ-012 out_valid SHALL drop after the out_ready handshake unless a new beat is accepted in the same cycle. out_data SHALL stay stable while out_valid && !out_ready.
REQ-013 clr SHALL take priority over all other inputs and SHALL:
- zero key_len and kidx;
- drop any held output (out_valid=0);
- enter IDLE.
REQ-014 All modular arithmetic SHALL use a 6-bit sum with a single conditional subtract of 26. No dividers are allowed; /6 and %6 come from a 26-entry constant mapping.

Reset
REQ-015 On rst the block SHALL asynchronously set all of the following, and key memory contents need not be cleared:
- state=IDLE, key_len=0, kidx=0;
- out_valid=0, out_data=0, out_err=0;
- in_ready=0, key_ready=1 (key_ready is combinational from state=IDLE).
REQ-016 rst asserted mid-stream SHALL discard any held output. After release, a key must be reloaded before in_ready rises.

Structure
REQ-017 A shared package hybrid_cipher_pkg SHALL hold:
- state enum;
- ALPHA=26, GRID_COLS=6, GRID_ROWS=5;
- ERR_WORD=16'h3F3F;
- functions polybius_enc(idx) and polybius_dec(row, col).
REQ-018 One sub-module, hybrid_key_store, SHALL hold the KEY_MAX x 5-bit key register file, write pointer/key_len, and wrapping read pointer kidx.

Verification
REQ-019 Encrypt, key "N": in_data "V" -> out_data "23" one cycle later with out_err=0. Key "A", in "A" -> "11".
REQ-020 Key "AB", encrypt "AAA" back-to-back with out_ready=1 -> "11","12","11" on consecutive cycles (wrap check).
REQ-021 Boundary values:
- key "Z", encrypt "Z" -> "51";
- key "N", decrypt "23" -> low byte "V";
- decrypt "56" and "17" -> 16'h3F3F with out_err=1, and the next valid beat uses an unchanged kidx.
REQ-022 Backpressure: out_ready=0 for 3 cycles -> in_ready=0, out_data held constant, no beat lost or duplicated after release.
REQ-023 Key loading:
- key "A1B" with key_last -> key_len=2;
- 17 letters with KEY_MAX=16 -> RUN at 16;
- clr mid-stream -> out_valid=0, key_len=0, IDLE;
- rst mid-stream -> all REQ-015 values.

Source files
------------

// File: rtl/hybrid_cipher_pkg.sv
// Shared types, constants and Polybius helpers for the hybrid Vigenere/Polybius stream cipher.
package hybrid_cipher_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    localparam int ALPHA     = 26;
    localparam int GRID_COLS = 6;
    localparam int GRID_ROWS = 5;

    localparam logic [15:0] ERR_WORD = 16'h3F3F;
    localparam logic [7:0]  CH_A     = 8'h41;
    localparam logic [7:0]  CH_Z     = 8'h5A;
    localparam logic [7:0]  CH_1     = 8'h31;

    // Letter index 0..25 -> {row digit, column digit}; row boundaries are a fixed table, no divider.
    function automatic logic [15:0] polybius_enc(input logic [4:0] idx);
        logic [2:0] row;
        logic [4:0] base;
        logic [4:0] col;
        if (idx >= 5'd24) begin
            row = 3'd4; base = 5'd24;
        end else if (idx >= 5'd18) begin
            row = 3'd3; base = 5'd18;
        end else if (idx >= 5'd12) begin
            row = 3'd2; base = 5'd12;
        end else if (idx >= 5'd6) begin
            row = 3'd1; base = 5'd6;
        end else begin
            row = 3'd0; base = 5'd0;
        end
        col = idx - base;
        return {CH_1 + {5'b0, row}, CH_1 + {3'b0, col}};
    endfunction

    // {digit pair} -> {ok, index}; ok clears for out-of-grid digits or a cell past 'Z'.
    function automatic logic [5:0] polybius_dec(input logic [7:0] row, input logic [7:0] col);
        logic [7:0] r;
        logic [7:0] cc;
        logic [5:0] c;
        logic       ok;
        r  = row - CH_1;
        cc = col - CH_1;
        ok = (r < 8'(GRID_ROWS)) && (cc < 8'(GRID_COLS));
        c  = 6'({r[2:0], 2'b00}) + 6'({r[2:0], 1'b0}) + 6'(cc[2:0]);
        ok = ok && (c < 6'(ALPHA));
        return {ok, c[4:0]};
    endfunction

endpackage

// File: rtl/hybrid_key_store.sv
// Key register file with append-only write pointer (key_len) and wrapping read pointer (kidx).
module hybrid_key_store
    import hybrid_cipher_pkg::*;
#(
    parameter int KEY_MAX = 16,
    parameter int KW      = $clog2(KEY_MAX)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [4:0]    wr_dat,
    input  logic          rd_adv,
    output logic [KW:0]   key_len,
    output logic [4:0]    rd_dat
);

    logic [4:0]    mem_q [KEY_MAX];
    logic [KW:0]   len_q, len_d;
    logic [KW-1:0] kidx_q, kidx_d;
    logic          wr_ok;

    assign wr_ok = wr_en && !clr && (len_q < (KW+1)'(KEY_MAX));

    always_comb begin
        len_d  = len_q;
        kidx_d = kidx_q;
        if (clr) begin
            len_d  = '0;
            kidx_d = '0;
        end else begin
            if (wr_ok)
                len_d = len_q + 1'b1;
            if (rd_adv)
                kidx_d = ({1'b0, kidx_q} == len_q - 1'b1) ? '0 : kidx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q  <= '0;
            kidx_q <= '0;
        end else begin
            len_q  <= len_d;
            kidx_q <= kidx_d;
        end
    end

    // Contents survive reset; key_len alone says which entries are meaningful.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem_q[len_q[KW-1:0]] <= wr_dat;
    end

    assign key_len = len_q;
    assign rd_dat  = mem_q[kidx_q];

endmodule

// File: rtl/hybrid_cipher_stream.sv
// Vigenere shift + 6-column Polybius stream cipher; one cycle beat-to-output,
// full throughput; in_ready drops while a held output is not being taken.
module hybrid_cipher_stream
    import hybrid_cipher_pkg::*;
#(
    parameter int KEY_MAX = 16,
    parameter int KW      = $clog2(KEY_MAX)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          key_valid,
    input  logic [7:0]    key_data,
    input  logic          key_last,
    output logic          key_ready,
    input  logic          mode,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [15:0]   out_data,
    output logic          out_err,
    output logic [KW:0]   key_len
);

    state_e      state_q, state_d;
    logic        out_valid_q, out_valid_d;
    logic [15:0] out_data_q, out_data_d;
    logic        out_err_q, out_err_d;

    logic        key_acc, key_wr, beat_acc, beat_ok;
    logic [KW:0] len_next;
    logic [4:0]  key_k, p_enc;
    logic        enc_ok;
    logic [5:0]  dec, sum_e, sum_d, mod_e, mod_d;
    logic [15:0] result;

    assign key_ready = (state_q != ST_RUN);
    assign in_ready  = (state_q == ST_RUN) && (!out_valid_q || out_ready);
    assign key_acc   = key_valid && key_ready && !clr;
    assign key_wr    = key_acc && (key_data >= CH_A) && (key_data <= CH_Z);
    assign len_next  = key_len + (KW+1)'(key_wr);
    assign beat_acc  = in_valid && in_ready && !clr;

    hybrid_key_store #(.KEY_MAX(KEY_MAX), .KW(KW)) u_key_store (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .wr_en   (key_wr),
        .wr_dat  (5'(key_data - CH_A)),
        .rd_adv  (beat_acc && beat_ok),
        .key_len (key_len),
        .rd_dat  (key_k)
    );

    // Both directions stay within 6 bits and need one conditional subtract of 26.
    always_comb begin
        p_enc  = 5'(in_data[7:0] - CH_A);
        enc_ok = (in_data[7:0] >= CH_A) && (in_data[7:0] <= CH_Z);
        sum_e  = {1'b0, p_enc} + {1'b0, key_k};
        mod_e  = (sum_e >= 6'(ALPHA)) ? sum_e - 6'(ALPHA) : sum_e;
        dec    = polybius_dec(in_data[15:8], in_data[7:0]);
        sum_d  = {1'b0, dec[4:0]} + (6'(ALPHA) - {1'b0, key_k});
        mod_d  = (sum_d >= 6'(ALPHA)) ? sum_d - 6'(ALPHA) : sum_d;
        beat_ok = mode ? dec[5] : enc_ok;
        if (!beat_ok)
            result = ERR_WORD;
        else if (mode)
            result = {8'h00, CH_A + {3'b0, mod_d[4:0]}};
        else
            result = polybius_enc(mod_e[4:0]);
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        if (clr) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
        end else begin
            if (key_acc) begin
                if (key_last)
                    state_d = (len_next != '0) ? ST_RUN : ST_IDLE;
                else if (len_next == (KW+1)'(KEY_MAX))
                    state_d = ST_RUN;
                else
                    state_d = ST_LOAD;
            end
            if (beat_acc) begin
                out_valid_d = 1'b1;
                out_data_d  = result;
                out_err_d   = !beat_ok;
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;

endmodule
